// File: rtl/ysyx_24100005_ifetch_sram.sv
// Fetch-side instruction memory: one outstanding PC request, response after LATENCY cycles.
// Misaligned or unmapped fetches answer with ebreak and rsp_err so the core halts.
module ysyx_24100005_ifetch_sram #(
   parameter int unsigned DEPTH   = 1024,
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_inst,
   output logic        rsp_err,
   input  logic        flush,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
);

   localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] addr_q;
   logic [31:0] mem [DEPTH];

   logic [31:0] rd_addr;
   logic [29:0] rd_word, ld_word;
   logic        rd_bad, ld_bad;
   logic        rd_now;

   // BASE is word aligned, so the word offset is just the difference of the upper bits.
   assign rd_addr = (state_q == StIdle) ? req_addr : addr_q;
   assign rd_word = rd_addr[31:2] - BASE[31:2];
   assign ld_word = ld_addr[31:2] - BASE[31:2];
   assign rd_bad  = (rd_addr[1:0] != 2'b00) || (rd_addr < BASE)
                    || ({2'b00, rd_word} >= 32'(DEPTH));
   assign ld_bad  = (ld_addr[1:0] != 2'b00) || (ld_addr < BASE)
                    || ({2'b00, ld_word} >= 32'(DEPTH));

   assign req_ready = (state_q == StIdle);

   // The array read happens on the edge that enters StResp.
   always_comb begin
      rd_now = 1'b0;
      if (state_q == StIdle) begin
         rd_now = req_valid && (LATENCY == 1);
      end else if (state_q == StWait) begin
         rd_now = (cnt_q == 4'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         addr_q    <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_inst  <= 32'h0;
         rsp_err   <= 1'b0;
      end else if (flush) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         rsp_valid <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  addr_q <= req_addr;
                  if (LATENCY == 1) begin
                     state_q <= StResp;
                  end else begin
                     state_q <= StWait;
                     cnt_q   <= 4'(LATENCY - 1);
                  end
               end
            end
            StWait: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= StResp;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  state_q   <= StIdle;
                  rsp_valid <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
         if (rd_now) begin
            rsp_valid <= 1'b1;
            rsp_err   <= rd_bad;
            rsp_inst  <= rd_bad ? EBREAK : mem[rd_word[IW-1:0]];
         end
      end
   end

   // Separate write process so a same-edge read sees the old word.
   always_ff @(posedge clk) begin
      if (rst && ld_en && !ld_bad) begin
         mem[ld_word[IW-1:0]] <= ld_data;
      end
   end

endmodule

// File: tb/tb_ysyx_24100005_ifetch_sram.sv
// Directed bench for the fetch SRAM: a LATENCY=2 instance and a LATENCY=1 instance
// sharing clock, reset, flush and the preload bus.
module tb_ysyx_24100005_ifetch_sram;

   logic        clk = 1'b0;
   logic        rst, flush, ld_en;
   logic [31:0] ld_addr, ld_data;

   logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, rsp_inst;
   logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_err1;
   logic [31:0] req_addr1, rsp_inst1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ysyx_24100005_ifetch_sram #(.DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(2)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
      .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   ysyx_24100005_ifetch_sram #(.DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_addr(req_addr1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_inst(rsp_inst1), .rsp_err(rsp_err1),
      .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   // Accept edge then read edge for the LATENCY=2 instance.
   task automatic fetch(input logic [31:0] a);
      req_valid = 1'b1; req_addr = a;
      tick();
      req_valid = 1'b0;
      tick();
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("hs_valid", {31'b0, rsp_valid}, 32'h0);
      chk("hs_ready", {31'b0, req_ready}, 32'h1);
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
      req_valid1 = 1'b0; req_addr1 = '0; rsp_ready1 = 1'b0;
      tick(); tick();
      chk("rst_valid", {31'b0, rsp_valid}, 32'h0);
      chk("rst_inst", rsp_inst, 32'h0);
      chk("rst_err", {31'b0, rsp_err}, 32'h0);
      chk("rst_ready", {31'b0, req_ready}, 32'h1);
      rst = 1'b1;

      load(32'h8000_0000, 32'h0010_0093);
      load(32'h8000_0004, 32'h1111_1111);
      load(32'h8000_0008, 32'h2222_2222);
      load(32'h8000_0FFC, 32'h3333_3333);
      load(32'h8000_1000, 32'h4444_4444);  // out of range, ignored

      // Basic fetch, latency 2
      req_valid = 1'b1; req_addr = 32'h8000_0000;
      tick();
      req_valid = 1'b0;
      chk("t1_ready_wait", {31'b0, req_ready}, 32'h0);
      chk("t1_valid_wait", {31'b0, rsp_valid}, 32'h0);
      tick();
      chk("t1_valid", {31'b0, rsp_valid}, 32'h1);
      chk("t1_inst", rsp_inst, 32'h0010_0093);
      chk("t1_err", {31'b0, rsp_err}, 32'h0);
      chk("t1_ready_resp", {31'b0, req_ready}, 32'h0);

      // Back-pressure: response held stable
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_hold_valid", {31'b0, rsp_valid}, 32'h1);
         chk("t2_hold_inst", rsp_inst, 32'h0010_0093);
      end
      handshake();

      // Error fetches
      fetch(32'h8000_0002);
      chk("t3_mis_err", {31'b0, rsp_err}, 32'h1);
      chk("t3_mis_inst", rsp_inst, 32'h0010_0073);
      handshake();
      fetch(32'h7FFF_FFFC);
      chk("t3_low_err", {31'b0, rsp_err}, 32'h1);
      chk("t3_low_inst", rsp_inst, 32'h0010_0073);
      handshake();
      fetch(32'h8000_1000);
      chk("t3_high_err", {31'b0, rsp_err}, 32'h1);
      chk("t3_high_inst", rsp_inst, 32'h0010_0073);
      handshake();
      fetch(32'h8000_0FFC);
      chk("t3_last_err", {31'b0, rsp_err}, 32'h0);
      chk("t3_last_inst", rsp_inst, 32'h3333_3333);
      handshake();

      // Write before the read edge is visible
      req_valid = 1'b1; req_addr = 32'h8000_0004;
      ld_en = 1'b1; ld_addr = 32'h8000_0004; ld_data = 32'hDEAD_BEEF;
      tick();
      req_valid = 1'b0; ld_en = 1'b0;
      tick();
      chk("t4_early_wr", rsp_inst, 32'hDEAD_BEEF);
      handshake();
      // Write on the read edge returns the old word
      req_valid = 1'b1; req_addr = 32'h8000_0008;
      tick();
      req_valid = 1'b0;
      ld_en = 1'b1; ld_addr = 32'h8000_0008; ld_data = 32'hCAFE_F00D;
      tick();
      ld_en = 1'b0;
      chk("t4_same_edge", rsp_inst, 32'h2222_2222);
      handshake();
      fetch(32'h8000_0008);
      chk("t4_after_wr", rsp_inst, 32'hCAFE_F00D);
      handshake();

      // Flush in WAIT
      req_valid = 1'b1; req_addr = 32'h8000_0000;
      tick();
      req_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_fw_valid", {31'b0, rsp_valid}, 32'h0);
      chk("t5_fw_ready", {31'b0, req_ready}, 32'h1);
      tick();
      chk("t5_fw_dropped", {31'b0, rsp_valid}, 32'h0);
      // Flush in RESP with rsp_ready
      fetch(32'h8000_0000);
      chk("t5_fr_pre", {31'b0, rsp_valid}, 32'h1);
      flush = 1'b1; rsp_ready = 1'b1;
      tick();
      flush = 1'b0; rsp_ready = 1'b0;
      chk("t5_fr_valid", {31'b0, rsp_valid}, 32'h0);
      chk("t5_fr_ready", {31'b0, req_ready}, 32'h1);
      // Flush with request in IDLE: not accepted
      flush = 1'b1; req_valid = 1'b1; req_addr = 32'h8000_0000;
      tick();
      flush = 1'b0; req_valid = 1'b0;
      chk("t5_fi_ready", {31'b0, req_ready}, 32'h1);
      tick();
      chk("t5_fi_valid", {31'b0, rsp_valid}, 32'h0);
      fetch(32'h8000_0000);
      chk("t5_next_inst", rsp_inst, 32'h0010_0093);
      chk("t5_next_valid", {31'b0, rsp_valid}, 32'h1);
      handshake();

      // Reset mid-WAIT
      req_valid = 1'b1; req_addr = 32'h8000_0004;
      tick();
      req_valid = 1'b0; rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("t6_rw_valid", {31'b0, rsp_valid}, 32'h0);
      chk("t6_rw_inst", rsp_inst, 32'h0);
      chk("t6_rw_ready", {31'b0, req_ready}, 32'h1);
      // Reset in RESP
      fetch(32'h8000_0004);
      chk("t6_pre_inst", rsp_inst, 32'hDEAD_BEEF);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("t6_rr_valid", {31'b0, rsp_valid}, 32'h0);
      chk("t6_rr_inst", rsp_inst, 32'h0);
      chk("t6_rr_err", {31'b0, rsp_err}, 32'h0);
      fetch(32'h8000_0004);
      chk("t6_kept", rsp_inst, 32'hDEAD_BEEF);
      handshake();

      // LATENCY=1 instance
      req_valid1 = 1'b1; req_addr1 = 32'h8000_0000;
      tick();
      req_valid1 = 1'b0;
      chk("l1_valid", {31'b0, rsp_valid1}, 32'h1);
      chk("l1_inst", rsp_inst1, 32'h0010_0093);
      chk("l1_ready", {31'b0, req_ready1}, 32'h0);
      rsp_ready1 = 1'b1;
      tick();
      rsp_ready1 = 1'b0;
      chk("l1_hs", {31'b0, rsp_valid1}, 32'h0);
      req_valid1 = 1'b1; req_addr1 = 32'h8000_0001;
      tick();
      req_valid1 = 1'b0;
      chk("l1_err", {31'b0, rsp_err1}, 32'h1);
      chk("l1_err_inst", rsp_inst1, 32'h0010_0073);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
